result_packer: RTL and testbench
================================

RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one convolution result.
REQ-002 SHALL have parameter LANES, default 4: results packed per memory word.
REQ-003 SHALL have parameter ADDR_W, default 8: output memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  pulse; opens a new output frame.
REQ-007 SHALL have port in_wr  input  1  result valid strobe from the convolution controller's wr path.
REQ-008 SHALL have port in_data  input  DATA_W  signed two's-complement result.
REQ-009 SHALL have port in_last  input  1  end of frame.
REQ-010 SHALL have port in_ready  output  1  block accepts in_wr this cycle.
REQ-011 SHALL have port mem_we  output  1  memory write request.
REQ-012 SHALL have port mem_addr  output  ADDR_W  word address.
REQ-013 SHALL have port mem_wdata  output  LANES*DATA_W  packed word.
REQ-014 SHALL have port mem_ready  input  1  memory accepts the write this cycle.
REQ-015 SHALL have port count  output  ADDR_W+1  words written in the current frame.
REQ-016 SHALL have port overflow  output  1  sticky address-wrap flag.
REQ-017 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-019 IDLE: in_ready=0; start=1 -> COLLECT; lane pointer, mem_addr, count, overflow cleared.
REQ-020 COLLECT: in_ready=1; in_wr stores in_data at lane[ptr], with lane 0 at the LSBs, then ptr+1.
REQ-021 COLLECT: in_wr with ptr==LANES-1, or in_wr with in_last=1 -> WRITE next cycle.
REQ-022 COLLECT: a partial word SHALL have its unfilled lanes equal to zero.
REQ-023 COLLECT: in_last=1 without in_wr and ptr>0 -> WRITE (flush); with ptr==0 -> DONE, no write.
REQ-024 WRITE: mem_we=1, in_ready=0; mem_addr and mem_wdata SHALL hold stable until mem_ready=1.
REQ-025 WRITE accept (mem_ready=1): mem_addr+1, count+1, lanes and ptr cleared; -> DONE if last latched, else COLLECT.
REQ-026 Latency: final lane in_wr at cycle t -> mem_we=1 at t+1; mem_ready=1 at t+1 -> in_ready=1 at t+2.
REQ-027 DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 in_wr while in_ready=0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-029 mem_addr wraps from 2^ADDR_W-1 to 0 on accept; the wrap SHALL set overflow, held until the next start.
REQ-030 count SHALL saturate at 2^(ADDR_W+1)-1.

Reset
REQ-031 rst=0 SHALL asynchronously force: IDLE, all lanes 0, ptr 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, overflow 0, done 0, in_ready 0.
REQ-032 rst asserted during WRITE SHALL abandon the word; mem_we falls without waiting for a clock edge.

Configuration
REQ-033 With RESULT_PACKER_RELU_EN defined, a negative in_data SHALL be stored as 0; without it, in_data SHALL be stored unmodified.

Structure
REQ-034 DATA_W, LANES and ADDR_W defaults plus the FSM state encoding SHALL live in the shared package cnn_pkg.
REQ-035 Address/count logic SHALL be one sub-module, result_addr_counter (en, clear, count, wrap out).

Verification
REQ-036 start; in_wr 0x01,0x02,0x03,0x04; mem_ready=1 -> one mem_we, addr 0x00, wdata 0x04030201, count 1.
REQ-037 Six writes 0x01..0x06, in_last on the 6th -> 0x04030201@0, 0x00000605@1, done the cycle after the second accept.
REQ-038 mem_ready=0 for 3 cycles in WRITE -> mem_we, addr and wdata stable for 3 cycles, in_ready=0, in_wr in that window dropped.
REQ-039 ADDR_W=8, 257 full words -> word 257 at addr 0x00, overflow=1, count 257.
REQ-040 in_data 0xFF: with RESULT_PACKER_RELU_EN -> lane 0x00; without -> lane 0xFF.
REQ-041 rst=0 mid-WRITE -> mem_we=0 immediately; after release, IDLE, count 0, next start restarts at addr 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths and packer FSM encoding for the convolution datapath (rev 1.0).
`default_nettype none

package cnn_pkg;

  localparam int CNN_DATA_W = 8;
  localparam int CNN_LANES  = 4;
  localparam int CNN_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } pk_state_t;

endpackage

`default_nettype wire

// File: rtl/result_addr_counter.sv
// result_addr_counter: word address with wrap strobe and saturating word count (rev 1.0).
`default_nettype none

module result_addr_counter
  import cnn_pkg::*;
#(
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_wrap
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;

  assign o_addr  = r_addr;
  assign o_count = r_count;
  assign o_wrap  = i_en && (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + 1'b1;
      if (r_count != {(ADDR_W+1){1'b1}})
        r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_packer.sv
// result_packer: packs LANES signed results per memory word (rev 1.0).
// Define RESULT_PACKER_RELU_EN to store negative results as zero.
`default_nettype none

module result_packer
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int LANES  = CNN_LANES,
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_wr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*DATA_W-1:0] mem_wdata,
  input  logic                    mem_ready,
  output logic [ADDR_W:0]         count,
  output logic                    overflow,
  output logic                    done
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(LANES - 1);

  pk_state_t               r_state;
  logic [PTR_W-1:0]        r_ptr;
  logic [LANES*DATA_W-1:0] r_word;
  logic                    r_last;
  logic                    r_in_ready;
  logic                    r_mem_we;
  logic                    r_done;
  logic                    r_overflow;

  logic [DATA_W-1:0]       w_data;
  logic                    w_accept;
  logic                    w_clear;
  logic                    w_wrap;

`ifdef RESULT_PACKER_RELU_EN
  assign w_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign w_data = in_data;
`endif

  assign w_accept = (r_state == ST_WRITE) && mem_ready;
  assign w_clear  = (r_state == ST_IDLE) && start;

  result_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_accept),
    .i_clear (w_clear),
    .o_addr  (mem_addr),
    .o_count (count),
    .o_wrap  (w_wrap)
  );

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_word;
  assign overflow  = r_overflow;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_COLLECT;
            r_ptr      <= '0;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (in_wr) begin
            r_word[int'(r_ptr)*DATA_W +: DATA_W] <= w_data;
            r_ptr <= r_ptr + 1'b1;
            if ((r_ptr == c_LAST_PTR) || in_last) begin
              r_state    <= ST_WRITE;
              r_last     <= in_last;
              r_mem_we   <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end else if (in_last) begin
            // Flush a partial word; an empty word ends the frame with no write.
            r_in_ready <= 1'b0;
            r_last     <= 1'b1;
            if (r_ptr != '0) begin
              r_state  <= ST_WRITE;
              r_mem_we <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            r_mem_we <= 1'b0;
            r_ptr    <= '0;
            r_word   <= '0;
            if (w_wrap)
              r_overflow <= 1'b1;
            if (r_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_COLLECT;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_packer.sv
// tb_result_packer: directed self-checking bench for result_packer (rev 1.0).
`default_nettype none

module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_wr;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [8:0]  count;
  logic        overflow;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_relu_word;

  always #5 clk = ~clk;

  result_packer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_wr     (in_wr),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .overflow  (overflow),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    in_wr   = 1'b1;
    in_data = d;
    in_last = l;
    tick();
    in_wr   = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
`ifdef RESULT_PACKER_RELU_EN
    exp_relu_word = 32'h007F_0000;
`else
    exp_relu_word = 32'h007F_80FF;
`endif
    rst = 1'b0; start = 1'b0; in_wr = 1'b0; in_data = '0; in_last = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_done", done, 0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Single full word
    begin_frame();
    check("collect_in_ready", in_ready, 1);
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0);
    check("partial_no_we", mem_we, 0);
    wr(8'h04, 0);
    check("w1_we", mem_we, 1);
    check("w1_addr", mem_addr, 8'h00);
    check("w1_wdata", mem_wdata, 32'h0403_0201);
    check("w1_in_ready", in_ready, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("w1_we_after", mem_we, 0);
    check("w1_count", count, 1);
    check("w1_in_ready_back", in_ready, 1);
    check("w1_addr_next", mem_addr, 8'h01);
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("empty_flush_done", done, 1);
    check("empty_flush_no_we", mem_we, 0);
    check("empty_flush_count", count, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", in_ready, 0);

    // Six results, partial second word
    begin_frame();
    check("f2_count_clear", count, 0);
    mem_ready = 1'b1;
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0);
    check("f2_w0_wdata", mem_wdata, 32'h0403_0201);
    check("f2_w0_addr", mem_addr, 8'h00);
    tick();
    check("f2_w0_count", count, 1);
    wr(8'h05, 0); wr(8'h06, 1);
    check("f2_w1_we", mem_we, 1);
    check("f2_w1_wdata", mem_wdata, 32'h0000_0605);
    check("f2_w1_addr", mem_addr, 8'h01);
    tick();
    check("f2_done", done, 1);
    check("f2_count", count, 2);
    tick();
    check("f2_done_low", done, 0);
    mem_ready = 1'b0;

    // Memory stall with writes attempted in the stall window
    begin_frame();
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'h44, 0);
    for (int i = 0; i < 3; i++) begin
      in_wr   = 1'b1;
      in_data = 8'h99;
      tick();
      check("stall_we", mem_we, 1);
      check("stall_addr", mem_addr, 8'h00);
      check("stall_wdata", mem_wdata, 32'h4433_2211);
      check("stall_in_ready", in_ready, 0);
    end
    in_wr = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("stall_count", count, 1);
    check("stall_we_low", mem_we, 0);
    wr(8'hFF, 0); wr(8'h80, 0); wr(8'h7F, 0); wr(8'h00, 1);
    check("sign_wdata", mem_wdata, exp_relu_word);
    check("sign_addr", mem_addr, 8'h01);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sign_done", done, 1);
    tick();

    // 257 words: address wraps, overflow set
    begin_frame();
    mem_ready = 1'b1;
    for (int w = 0; w < 257; w++) begin
      wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0);
      if (w == 256) begin
        check("wrap_w257_addr", mem_addr, 8'h00);
        check("wrap_w257_we", mem_we, 1);
      end
      tick();
      if (w == 254) begin
        check("wrap_pre_addr", mem_addr, 8'hFF);
        check("wrap_pre_ovf", overflow, 0);
      end
      if (w == 255) begin
        check("wrap_addr", mem_addr, 8'h00);
        check("wrap_ovf", overflow, 1);
        check("wrap_count256", count, 256);
      end
    end
    check("wrap_count257", count, 257);
    check("wrap_addr_after", mem_addr, 8'h01);
    mem_ready = 1'b0;
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("wrap_done", done, 1);
    tick();
    check("ovf_held_idle", overflow, 1);
    begin_frame();
    check("ovf_cleared", overflow, 0);
    check("count_cleared", count, 0);
    check("addr_cleared", mem_addr, 8'h00);

    // Reset during a stalled write
    wr(8'hA1, 0); wr(8'hA2, 0); wr(8'hA3, 0); wr(8'hA4, 0);
    check("rst_pre_we", mem_we, 1);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_we", mem_we, 0);
    check("rst_async_wdata", mem_wdata, 0);
    check("rst_async_count", count, 0);
    check("rst_async_in_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    tick();
    check("rst_idle", in_ready, 0);
    begin_frame();
    wr(8'hB1, 0); wr(8'hB2, 0); wr(8'hB3, 0); wr(8'hB4, 0);
    check("restart_addr", mem_addr, 8'h00);
    check("restart_wdata", mem_wdata, 32'hB4B3_B2B1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("restart_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
